decode_stage: RTL

// RV32I instruction decode stage, directly upstream of the register file's read ports and of execute.
// - Latches fetched instructions and drives the read addresses ar1o/ar2o.
// - Merges register data with a writeback bypass and generates the immediate.
// - Interlocks on outstanding loads.
// - Hands a registered decoded bundle to execute over a valid/ready handshake.

---
 rtl/decode_stage.sv | 239 +++++++++++++++++++++++
 1 files changed

// File: rtl/decode_stage.sv
// RV32I decode stage: holds one fetched instruction, reads the register file, bypasses writeback,
// builds the immediate, interlocks on outstanding loads and hands a registered bundle to execute.
module decode_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush_i,
  input  logic            if_valid_i,
  output logic            if_ready_o,
  input  logic [31:0]     if_instr_i,
  input  logic [XLEN-1:0] if_pc_i,
  output logic [4:0]      ar1o,
  output logic [4:0]      ar2o,
  input  logic [XLEN-1:0] r1i,
  input  logic [XLEN-1:0] r2i,
  input  logic            wb_we_i,
  input  logic [4:0]      wb_ar_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [XLEN-1:0] ex_pc_o,
  output logic [XLEN-1:0] ex_rs1_o,
  output logic [XLEN-1:0] ex_rs2_o,
  output logic [XLEN-1:0] ex_imm_o,
  output logic [4:0]      ex_rd_o,
  output logic [6:0]      ex_opcode_o,
  output logic [2:0]      ex_funct3_o,
  output logic            ex_funct7b5_o,
  output logic            ex_illegal_o
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  function automatic logic [XLEN-1:0] imm_gen(input logic [31:0] ins);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (ins[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM:
        imm = {{20{ins[31]}}, ins[31:20]};
      OP_STORE:
        imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      OP_BRANCH:
        imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm = {ins[31:12], 12'h000};
      OP_JAL:
        imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default:
        imm = '0;
    endcase
    return imm;
  endfunction

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_FENCE, OP_IMM, OP_AUIPC, OP_STORE, OP_REG,
      OP_LUI, OP_BRANCH, OP_JALR, OP_JAL, OP_SYSTEM: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM, OP_STORE, OP_REG, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    case (op)
      OP_STORE, OP_REG, OP_BRANCH: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // x0 reads as zero; a same-cycle writeback beats the (stale) regfile read.
  function automatic logic [XLEN-1:0] sel_operand(input logic [4:0] rs,
                                                  input logic [XLEN-1:0] rf_data,
                                                  input logic we,
                                                  input logic [4:0] ar,
                                                  input logic [XLEN-1:0] data);
    if (rs == 5'd0)           return '0;
    else if (we && ar == rs)  return data;
    else                      return rf_data;
  endfunction

  logic            d_valid_q, d_valid_d;
  logic [31:0]     d_instr_q, d_instr_d;
  logic [XLEN-1:0] d_pc_q, d_pc_d;

  logic            ex_valid_q, ex_valid_d;
  logic [XLEN-1:0] ex_pc_q, ex_pc_d;
  logic [XLEN-1:0] ex_rs1_q, ex_rs1_d;
  logic [XLEN-1:0] ex_rs2_q, ex_rs2_d;
  logic [XLEN-1:0] ex_imm_q, ex_imm_d;
  logic [4:0]      ex_rd_q, ex_rd_d;
  logic [6:0]      ex_opcode_q, ex_opcode_d;
  logic [2:0]      ex_funct3_q, ex_funct3_d;
  logic            ex_funct7b5_q, ex_funct7b5_d;
  logic            ex_illegal_q, ex_illegal_d;

  logic            pending_q, pending_d;
  logic [4:0]      pend_rd_q, pend_rd_d;

  logic [6:0] d_op;
  logic [4:0] d_rs1, d_rs2, d_rd;
  logic       pend_clr, hazard, adv, if_ready;

  assign d_op  = d_instr_q[6:0];
  assign d_rd  = d_instr_q[11:7];
  assign d_rs1 = d_instr_q[19:15];
  assign d_rs2 = d_instr_q[24:20];

  // A writeback that retires the pending load releases the interlock in the same cycle.
  assign pend_clr = pending_q && wb_we_i && (wb_ar_i == pend_rd_q);
  assign hazard   = pending_q && !pend_clr &&
                    ((uses_rs1(d_op) && d_rs1 != 5'd0 && d_rs1 == pend_rd_q) ||
                     (uses_rs2(d_op) && d_rs2 != 5'd0 && d_rs2 == pend_rd_q));
  assign adv      = d_valid_q && !hazard && (!ex_valid_q || ex_ready_i);
  assign if_ready = !d_valid_q || adv;

  always_comb begin
    d_valid_d     = d_valid_q;
    d_instr_d     = d_instr_q;
    d_pc_d        = d_pc_q;
    ex_valid_d    = ex_valid_q;
    ex_pc_d       = ex_pc_q;
    ex_rs1_d      = ex_rs1_q;
    ex_rs2_d      = ex_rs2_q;
    ex_imm_d      = ex_imm_q;
    ex_rd_d       = ex_rd_q;
    ex_opcode_d   = ex_opcode_q;
    ex_funct3_d   = ex_funct3_q;
    ex_funct7b5_d = ex_funct7b5_q;
    ex_illegal_d  = ex_illegal_q;
    pending_d     = pending_q;
    pend_rd_d     = pend_rd_q;

    if (flush_i) begin
      d_valid_d  = 1'b0;
      ex_valid_d = 1'b0;
      pending_d  = 1'b0;
    end else begin
      if (if_valid_i && if_ready) begin
        d_valid_d = 1'b1;
        d_instr_d = if_instr_i;
        d_pc_d    = if_pc_i;
      end else if (adv) begin
        d_valid_d = 1'b0;
      end

      if (adv) begin
        ex_valid_d    = 1'b1;
        ex_pc_d       = d_pc_q;
        ex_rs1_d      = sel_operand(d_rs1, r1i, wb_we_i, wb_ar_i, wb_data_i);
        ex_rs2_d      = sel_operand(d_rs2, r2i, wb_we_i, wb_ar_i, wb_data_i);
        ex_imm_d      = imm_gen(d_instr_q);
        ex_rd_d       = d_rd;
        ex_opcode_d   = d_op;
        ex_funct3_d   = d_instr_q[14:12];
        ex_funct7b5_d = d_instr_q[30];
        ex_illegal_d  = !is_legal(d_op);
      end else if (ex_ready_i) begin
        ex_valid_d = 1'b0;
      end

      // A newly issued load takes precedence over a clear arriving in the same cycle.
      if (adv && d_op == OP_LOAD && d_rd != 5'd0) begin
        pending_d = 1'b1;
        pend_rd_d = d_rd;
      end else if (pend_clr) begin
        pending_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_valid_q     <= 1'b0;
      d_instr_q     <= '0;
      d_pc_q        <= '0;
      ex_valid_q    <= 1'b0;
      ex_pc_q       <= RESET_PC;
      ex_rs1_q      <= '0;
      ex_rs2_q      <= '0;
      ex_imm_q      <= '0;
      ex_rd_q       <= '0;
      ex_opcode_q   <= '0;
      ex_funct3_q   <= '0;
      ex_funct7b5_q <= 1'b0;
      ex_illegal_q  <= 1'b0;
      pending_q     <= 1'b0;
      pend_rd_q     <= '0;
    end else begin
      d_valid_q     <= d_valid_d;
      d_instr_q     <= d_instr_d;
      d_pc_q        <= d_pc_d;
      ex_valid_q    <= ex_valid_d;
      ex_pc_q       <= ex_pc_d;
      ex_rs1_q      <= ex_rs1_d;
      ex_rs2_q      <= ex_rs2_d;
      ex_imm_q      <= ex_imm_d;
      ex_rd_q       <= ex_rd_d;
      ex_opcode_q   <= ex_opcode_d;
      ex_funct3_q   <= ex_funct3_d;
      ex_funct7b5_q <= ex_funct7b5_d;
      ex_illegal_q  <= ex_illegal_d;
      pending_q     <= pending_d;
      pend_rd_q     <= pend_rd_d;
    end
  end

  assign if_ready_o    = if_ready;
  assign ar1o          = d_rs1;
  assign ar2o          = d_rs2;
  assign ex_valid_o    = ex_valid_q;
  assign ex_pc_o       = ex_pc_q;
  assign ex_rs1_o      = ex_rs1_q;
  assign ex_rs2_o      = ex_rs2_q;
  assign ex_imm_o      = ex_imm_q;
  assign ex_rd_o       = ex_rd_q;
  assign ex_opcode_o   = ex_opcode_q;
  assign ex_funct3_o   = ex_funct3_q;
  assign ex_funct7b5_o = ex_funct7b5_q;
  assign ex_illegal_o  = ex_illegal_q;

endmodule
